mm2s_result_drain: RTL and testbench

//  Downstream stage of the S2MM loader and systolic array. Collects the M x M result matrix

---
 rtl/mm_pkg.sv | 21 ++
 rtl/mm2s_result_buf.sv | 30 +++
 rtl/mm2s_result_drain.sv | 122 ++++++++++++
 tb/tb_mm2s_result_drain.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the MM2S result drain.
//  drain_state_t : COLLECT (load result beats), DRAIN (stream words), DONE (one-cycle wrap-up)
//  RES_WORDS / RES_BEATS : matrix size in words / input beats for the default geometry
//  sext32()      : sign-extend the low w bits of v to 32 bits
package mm_pkg;
  localparam int M         = 8;
  localparam int N2        = 4;
  localparam int D_W       = 8;
  localparam int ACC_W     = 2*D_W + $clog2(M);
  localparam int RES_WORDS = M*M;
  localparam int RES_BEATS = M*M/N2;

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} drain_state_t;

  // w must be a constant in 1..32 at every call site so this folds to wiring.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction
endpackage

// File: rtl/mm2s_result_buf.sv
// Result buffer: simple dual-port RAM.
//  clk      : clock
//  wr_en    : write LANES consecutive words starting at wr_addr
//  wr_addr  : base address of the write (lane k goes to wr_addr+k)
//  wr_data  : LANES words
//  rd_en    : capture mem[rd_addr] into rd_data on this edge; rd_data holds otherwise
//  rd_addr  : read address
//  rd_data  : registered read data
module mm2s_result_buf #(
  parameter int W     = 19,
  parameter int DEPTH = 64,
  parameter int LANES = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data [LANES],
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int k = 0; k < LANES; k++) mem[wr_addr + AW'(k)] <= wr_data[k];
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mm2s_result_drain.sv
// Collects an M x M result matrix from the systolic array as beats of N2
// accumulators, buffers it, then streams it row-major as 32-bit AXI-Stream
// words (sign-extended) with tlast on the final word, and re-arms.
//  clk, rst            : clock, synchronous active-high reset
//  res_valid/ready/data: result beat input; lane k of beat b is word b*N2+k
//  m_axis_mm2s_*       : output stream (tkeep constant all-ones)
//  done                : one-cycle pulse after the final word handshake
//  overflow            : sticky, a beat was offered while res_ready was low
module mm2s_result_drain #(
  parameter int M     = 8,
  parameter int N2    = 4,
  parameter int D_W   = 8,
  parameter int ACC_W = 2*D_W + $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [ACC_W-1:0] res_data [N2],
  output logic [31:0]      m_axis_mm2s_tdata,
  output logic [3:0]       m_axis_mm2s_tkeep,
  output logic             m_axis_mm2s_tlast,
  output logic             m_axis_mm2s_tvalid,
  input  logic             m_axis_mm2s_tready,
  output logic             done,
  output logic             overflow
);
  import mm_pkg::*;

  localparam int WORDS = M*M;
  localparam int BEATS = WORDS/N2;
  localparam int AW    = $clog2(WORDS);
  localparam int CW    = AW + 1;

  drain_state_t     state;
  logic [CW-1:0]    wr_beat, rd_idx;
  logic             rd_vld;      // rd_data holds word rd_idx-1, not yet moved to output
  logic [ACC_W-1:0] rd_data;
  logic             accept, load_out, rd_en, hs;

  assign m_axis_mm2s_tkeep = 4'hF;

  assign accept   = res_valid & res_ready;
  assign hs       = m_axis_mm2s_tvalid & m_axis_mm2s_tready;
  // Output register refills when empty or emptied this cycle.
  assign load_out = (state == DRAIN) & rd_vld & (~m_axis_mm2s_tvalid | m_axis_mm2s_tready);
  // Issue a read only if the read register has room after this edge, so the
  // pipeline never drops a word under backpressure.
  assign rd_en    = (state == DRAIN) & (rd_idx < CW'(WORDS)) & (~rd_vld | load_out);

  mm2s_result_buf #(.W(ACC_W), .DEPTH(WORDS), .LANES(N2)) u_buf (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(AW'(int'(wr_beat) * N2)),
    .wr_data(res_data),
    .rd_en  (rd_en),
    .rd_addr(rd_idx[AW-1:0]),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= COLLECT;
      wr_beat            <= '0;
      rd_idx             <= '0;
      rd_vld             <= 1'b0;
      res_ready          <= 1'b0;
      m_axis_mm2s_tdata  <= '0;
      m_axis_mm2s_tlast  <= 1'b0;
      m_axis_mm2s_tvalid <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= overflow | (res_valid & ~res_ready);
      case (state)
        COLLECT: begin
          res_ready <= 1'b1;
          if (accept) begin
            wr_beat <= wr_beat + 1'b1;
            if (wr_beat == CW'(BEATS-1)) begin
              state     <= DRAIN;
              res_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          res_ready <= 1'b0;
          if (rd_en) begin
            rd_idx <= rd_idx + 1'b1;
            rd_vld <= 1'b1;
          end else if (load_out) begin
            rd_vld <= 1'b0;
          end
          if (load_out) begin
            m_axis_mm2s_tdata  <= sext32(32'(rd_data), ACC_W);
            // rd_data is word rd_idx-1, so the last word is loaded when rd_idx == WORDS.
            m_axis_mm2s_tlast  <= (rd_idx == CW'(WORDS));
            m_axis_mm2s_tvalid <= 1'b1;
          end else if (hs) begin
            m_axis_mm2s_tvalid <= 1'b0;
            m_axis_mm2s_tlast  <= 1'b0;
          end
          if (hs & m_axis_mm2s_tlast) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state              <= COLLECT;
          wr_beat            <= '0;
          rd_idx             <= '0;
          rd_vld             <= 1'b0;
          res_ready          <= 1'b1;
          m_axis_mm2s_tvalid <= 1'b0;
          m_axis_mm2s_tlast  <= 1'b0;
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_mm2s_result_drain.sv
module tb_mm2s_result_drain;
  localparam int WORDS = 64;
  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [18:0] res_data [4];
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, done, overflow;
  logic        tready = 1'b0;

  int checks = 0;
  int errors = 0;
  int total  = 0;   // words handshaken since the last reset of this counter

  logic [18:0] val [WORDS];
  logic [31:0] exp_w [WORDS];

  always #5 clk = ~clk;

  mm2s_result_drain dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .m_axis_mm2s_tdata(tdata), .m_axis_mm2s_tkeep(tkeep), .m_axis_mm2s_tlast(tlast),
    .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready),
    .done(done), .overflow(overflow)
  );

  // mode 0: val[i]=i; mode 1: mix of negative / extreme values
  task automatic set_pattern(input int mode);
    for (int i = 0; i < WORDS; i++) begin
      if (mode == 0) begin
        val[i] = 19'(i); exp_w[i] = 32'(i);
      end else begin
        case (i % 4)
          0: begin val[i] = 19'h7FFFF; exp_w[i] = 32'hFFFFFFFF; end
          1: begin val[i] = 19'h40000; exp_w[i] = 32'hFFFC0000; end
          2: begin val[i] = 19'(i);    exp_w[i] = 32'(i);       end
          default: begin val[i] = 19'h3FFFF; exp_w[i] = 32'h0003FFFF; end
        endcase
      end
    end
  endtask

  task automatic load_matrix();
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b1) begin errors++; $display("FAIL load_ready beat %0d: got %b exp 1", b, res_ready); end
      res_valid = 1'b1;
      for (int k = 0; k < 4; k++) res_data[k] = val[b*4+k];
    end
    @(negedge clk);  // one cycle after the last accept
    res_valid = 1'b0;
    checks++;
    if (res_ready !== 1'b0 || tvalid !== 1'b0) begin
      errors++; $display("FAIL load_end: ready %b tvalid %b exp 0 0", res_ready, tvalid);
    end
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: tvalid %b exp 0", tvalid); end
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b1 || tdata !== exp_w[0] || tlast !== 1'b0) begin
      errors++; $display("FAIL latency_first: tvalid %b tdata %h tlast %b exp 1 %h 0", tvalid, tdata, tlast, exp_w[0]);
    end
  endtask

  // Drain with tready high pct% of cycles; stop early after stop_after words (0 = full);
  // inject offers extra beats mid-drain.
  task automatic drain(input int pct, input int stop_after, input bit inject);
    int got = 0, cyc = 0, first = -1, last = -1;
    bit stalled = 1'b0, fin = 1'b0;
    logic [31:0] held = '0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== held) begin
          errors++; $display("FAIL stall_hold: tvalid %b tdata %h exp 1 %h", tvalid, tdata, held);
        end
      end
      if (got == WORDS) begin
        checks++;
        if (done !== 1'b1 || res_ready !== 1'b0 || tvalid !== 1'b0) begin
          errors++; $display("FAIL done_pulse: done %b ready %b tvalid %b exp 1 0 0", done, res_ready, tvalid);
        end
        fin = 1'b1;
        tready = 1'b0;
        res_valid = 1'b0;
      end else begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_early at word %0d: got %b exp 0", got, done); end
        tready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        res_valid = inject && got >= 10 && got < 13;
        if (res_valid) begin
          for (int k = 0; k < 4; k++) res_data[k] = 19'h55555;
          checks++;
          if (res_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b exp 0", res_ready); end
        end
        if (tvalid && tready) begin
          checks++;
          if (tdata !== exp_w[got] || tlast !== (got == WORDS-1)) begin
            errors++; $display("FAIL word %0d: tdata %h tlast %b exp %h %b", total, tdata, tlast, exp_w[got], got == WORDS-1);
          end
          if (first < 0) first = cyc;
          last = cyc;
          got++; total++;
          stalled = 1'b0;
          if (stop_after > 0 && got == stop_after) fin = 1'b1;
        end else begin
          stalled = tvalid;
          held = tdata;
        end
      end
    end
    res_valid = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL drain_timeout: words %0d exp %0d", got, WORDS); end
    if (pct >= 100 && stop_after == 0) begin
      checks++;
      if (last - first != WORDS-1) begin errors++; $display("FAIL back_to_back_words: span %0d exp %0d", last - first, WORDS-1); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; tready = 1'b0; res_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tvalid !== 0 || tlast !== 0 || tdata !== 0 || done !== 0 || overflow !== 0 || res_ready !== 0 || tkeep !== 4'hF) begin
      errors++; $display("FAIL reset_state: tv %b tl %b td %h dn %b ov %b rdy %b keep %h exp 0 0 0 0 0 0 f",
                         tvalid, tlast, tdata, done, overflow, res_ready, tkeep);
    end
    @(negedge clk);
    checks++;
    if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", res_ready); end
  endtask

  task automatic test_basic();
    set_pattern(0); total = 0;
    load_matrix();
    drain(100, 0, 1'b0);
  endtask

  task automatic test_negative();
    set_pattern(1); total = 0;
    load_matrix();
    drain(100, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_pattern(0); total = 0;
    load_matrix();
    drain(30, 0, 1'b0);
    checks++;
    if (total != WORDS) begin errors++; $display("FAIL bp_count: got %0d exp %0d", total, WORDS); end
  endtask

  task automatic test_overflow();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pre: got %b exp 0", overflow); end
    set_pattern(1); total = 0;
    load_matrix();
    drain(70, 0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b exp 1", overflow); end
  endtask

  task automatic test_mid_reset();
    set_pattern(0); total = 0;
    load_matrix();
    drain(100, 8, 1'b0);
    rst = 1'b1; tready = 1'b0;
    @(negedge clk);
    checks++;
    if (tvalid !== 0 || tlast !== 0 || done !== 0 || overflow !== 0 || res_ready !== 0) begin
      errors++; $display("FAIL mid_reset: tv %b tl %b dn %b ov %b rdy %b exp 0 0 0 0 0", tvalid, tlast, done, overflow, res_ready);
    end
    rst = 1'b0;
    @(negedge clk);  // res_ready rises here
    set_pattern(1); total = 0;
    load_matrix();
    drain(100, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_pattern(0); total = 0;
    load_matrix();
    drain(100, 0, 1'b0);
    load_matrix();   // first beat driven the cycle right after done
    drain(100, 0, 1'b0);
    checks++;
    if (total != 2*WORDS) begin errors++; $display("FAIL b2b_count: got %0d exp %0d", total, 2*WORDS); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) res_data[k] = '0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
